id_ex_pipe_reg: RTL
===================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the pipelined processor, placed between the register-file read in ID and the ALU in EX. It captures, for each of NUM_SRC source channels, the decoded instruction, its source register addresses and operands. It supports stall (hold) and flush (bubble insertion). While it holds an instruction, it snoops the writeback port so held operands never go stale. It also keeps a saturating count of inserted bubbles for performance debug.

## Interface
Parameters:
- INSTR_W, 20, instruction word width
- DATA_W, 20, operand width
- NUM_SRC, 2, number of source operand channels (1..4)
- AW, 3, register address width
- ZERO_REG, 1, when 1 register address 0 is hardwired zero and is never snooped
- CNT_W, 8, bubble counter width

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  ID stage presents a real instruction
- in_instr  in  INSTR_W  decoded instruction from ID
- in_src_addr  in  NUM_SRC*AW  source register addresses; channel i at [i*AW +: AW]
- in_read_data  in  NUM_SRC*DATA_W  register-file read data; channel i at [i*DATA_W +: DATA_W]
- stall  in  1  hold current contents
- flush  in  1  squash; insert bubble
- wb_en  in  1  register-file write this cycle
- wb_addr  in  AW  writeback destination
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  EX holds a real instruction
- out_instr  out  INSTR_W  instruction to EX
- out_src_addr  out  NUM_SRC*AW  latched source addresses
- out_data  out  NUM_SRC*DATA_W  latched operands, per channel
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Per-cycle priority: reset > flush > stall > load.
- **Reset:** out_valid=0, out_instr=0, out_src_addr=0, out_data=0, bubble_count=0.
- **Flush** (wins over stall):
  - out_valid=0, out_instr=0 (NOP encoding), out_src_addr=0, out_data=0.
  - bubble_count increments.
- **Stall** (flush=0):
  - out_valid, out_instr and out_src_addr hold.
  - Per channel i, out_data[i] holds unless the snoop hit below applies.
  - bubble_count unchanged.
- **Held-operand snoop hit:** out_valid=1, wb_en=1, wb_addr==out_src_addr[i], and not (ZERO_REG=1 and wb_addr==0). On a hit, out_data[i]<=wb_data.
- **Load with in_valid=1:**
  - out_valid=1, out_instr<=in_instr, out_src_addr<=in_src_addr.
  - Per channel, out_data[i]<=in_read_data[i] by default.
  - Same-cycle writeback bypass: if wb_en=1 and wb_addr==in_src_addr[i] (same zero-register exclusion), capture wb_data instead.
- **Load with in_valid=0:** identical to flush, including the bubble_count increment.
- **Operand independence:** every channel updates independently. No channel ever holds while another loads, except on a per-channel snoop hit during stall.
- **bubble_count saturation:** saturates at 2^CNT_W-1 and never wraps.
- **stall with out_valid=0:** the bubble simply persists. No increment, no snoop.

## Timing
- Latency: 1 cycle, input to output, on load.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Snoop updates become visible the cycle after the wb_en pulse.
- flush and stall both high in the same cycle: treated as flush.
- Reset asserted mid-stall: the next cycle shows all-zero outputs. The stalled instruction is lost.
- wb_en with wb_addr matching several channels: all matching channels update in that cycle.

## Test plan
- **Reset mid-stall:** reset for 2 cycles, then load in_instr=20'hABCDE, data {20'h00005, 20'h00003}. Expected: out_valid=1, out_instr=20'hABCDE, out_data ch0=5, ch1=3 one cycle later. Then assert reset while stall=1. Expected: every output 0, bubble_count=0.
- **Independent channels:** load src_addr ch0=1, ch1=2, data 7 and 9. Expected: ch1 shows 9, not the previous or reset value, confirming both channels load.
- **Stall with snoop hit:** load src ch0=4, ch1=5, data 1 and 2, then stall=1 for 3 cycles. In cycle 2 drive wb_en=1, wb_addr=5, wb_data=20'h0FFFF. Expected: out_data ch1=20'h0FFFF from cycle 3, ch0=1, and out_instr held.
- **Same-cycle bypass and zero register:**
  - Load with in_src_addr ch0=3, wb_en=1, wb_addr=3, wb_data=20'h12345, in_read_data ch0=20'h00000. Expected: out_data ch0=20'h12345.
  - Repeat with addr 0 and ZERO_REG=1. Expected: out_data ch0 takes in_read_data.
- **Flush against stall:** flush=1 and stall=1 in the same cycle. Expected: out_valid=0, out_instr=0, bubble_count=1. Next, load with in_valid=0. Expected: bubble_count=2.
- **Counter saturation:** with CNT_W=2, insert 5 consecutive bubbles. Expected: bubble_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: ID-side payload, hazard controls, writeback
// snoop port and the EX-side registered outputs.
//   master : driven by ID/hazard/writeback logic, observes EX outputs
//   slave  : the pipeline register itself
interface id_ex_pipe_reg_if #(
    parameter int unsigned INSTR_W = 20,
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned AW      = 3,
    parameter int unsigned CNT_W   = 8
);
    logic                        in_valid;
    logic [INSTR_W-1:0]          in_instr;
    logic [NUM_SRC*AW-1:0]       in_src_addr;
    logic [NUM_SRC*DATA_W-1:0]   in_read_data;
    logic                        stall;
    logic                        flush;
    logic                        wb_en;
    logic [AW-1:0]               wb_addr;
    logic [DATA_W-1:0]           wb_data;
    logic                        out_valid;
    logic [INSTR_W-1:0]          out_instr;
    logic [NUM_SRC*AW-1:0]       out_src_addr;
    logic [NUM_SRC*DATA_W-1:0]   out_data;
    logic [CNT_W-1:0]            bubble_count;

    modport master (
        output in_valid, in_instr, in_src_addr, in_read_data,
        output stall, flush, wb_en, wb_addr, wb_data,
        input  out_valid, out_instr, out_src_addr, out_data, bubble_count
    );

    modport slave (
        input  in_valid, in_instr, in_src_addr, in_read_data,
        input  stall, flush, wb_en, wb_addr, wb_data,
        output out_valid, out_instr, out_src_addr, out_data, bubble_count
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush, writeback snoop on held
// operands, same-cycle writeback bypass on load, and a saturating bubble
// counter.
//   clock  : single clock, posedge
//   reset  : synchronous, active-high
//   bus    : id_ex_pipe_reg_if.slave (ID payload, stall/flush, wb port,
//            registered EX outputs and bubble_count)
// Parameters must match those of the connected interface instance.
module id_ex_pipe_reg #(
    parameter int unsigned INSTR_W  = 20,
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned AW       = 3,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    id_ex_pipe_reg_if.slave   bus
);
    localparam int unsigned SRC_W  = NUM_SRC * AW;
    localparam int unsigned DATA_T = NUM_SRC * DATA_W;

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [SRC_W-1:0]   src_q,   src_d;
    logic [DATA_T-1:0]  data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Writeback matches a source address; address 0 never matches when hardwired.
    function automatic logic wb_hit(input logic en, input logic [AW-1:0] wa,
                                    input logic [AW-1:0] sa);
        return en && (wa == sa) && !((ZERO_REG != 0) && (wa == '0));
    endfunction

    // Next-state: flush / bubble-load > stall (with snoop) > load (with bypass).
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        src_d   = src_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            valid_d = 1'b0;
            instr_d = '0;
            src_d   = '0;
            data_d  = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.stall) begin
            // A held bubble stays a bubble; only real held operands are refreshed.
            if (valid_q) begin
                for (int i = 0; i < int'(NUM_SRC); i++) begin
                    if (wb_hit(bus.wb_en, bus.wb_addr, src_q[i*AW +: AW])) begin
                        data_d[i*DATA_W +: DATA_W] = bus.wb_data;
                    end
                end
            end
        end else begin
            valid_d = 1'b1;
            instr_d = bus.in_instr;
            src_d   = bus.in_src_addr;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (wb_hit(bus.wb_en, bus.wb_addr, bus.in_src_addr[i*AW +: AW])) begin
                    data_d[i*DATA_W +: DATA_W] = bus.wb_data;
                end else begin
                    data_d[i*DATA_W +: DATA_W] = bus.in_read_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            src_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_instr    = instr_q;
    assign bus.out_src_addr = src_q;
    assign bus.out_data     = data_q;
    assign bus.bubble_count = cnt_q;
endmodule
